// File: rtl/alu_seq.sv
// alu_seq: sequential add/sub/shift-add mul/restoring div unit.
// Optional divider enabled by defining ALU_SEQ_DIV_EN.
module alu_seq #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         func,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       func_q, func_d;
  logic [W2-1:0]    opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    out_q, out_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [W2-1:0]    mul_acc;
  logic             long_op;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic             div_zero;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign out  = out_q;
  assign ovf  = ovf_q;

  // Datapath for one step: single-cycle results plus one mul/div iteration.
  always_comb begin
    sum     = {1'b0, opa_q[WIDTH-1:0]} + {1'b0, opb_q};
    diff    = opa_q[WIDTH-1:0] - opb_q;
    mul_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
`ifdef ALU_SEQ_DIV_EN
    // Remainder stays below the divisor, so W-bit subtraction is exact.
    rem_sh   = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, opa_q[WIDTH-1:0]};
    div_rem  = div_ge ? (rem_sh[WIDTH-1:0] - opa_q[WIDTH-1:0])
                      : rem_sh[WIDTH-1:0];
    div_quo  = {opb_q[WIDTH-2:0], div_ge};
    div_zero = (opa_q[WIDTH-1:0] == '0);
    long_op  = (func == 2'b10) || ((func == 2'b11) && (b != '0));
`else
    long_op  = (func == 2'b10);
`endif
  end

  // Next-state, operand latching, iteration and result write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          func_d  = func;
          acc_d   = '0;
          cnt_d   = long_op ? CW'(WIDTH) : CW'(1);
          // Divider takes the divisor in opa and shifts the dividend in opb.
          if (func == 2'b11) begin
            opa_d = {{WIDTH{1'b0}}, b};
            opb_d = a;
          end else begin
            opa_d = {{WIDTH{1'b0}}, a};
            opb_d = b;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (func_q == 2'b10) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
`ifdef ALU_SEQ_DIV_EN
        if (func_q == 2'b11) begin
          acc_d = {{WIDTH{1'b0}}, div_rem};
          opb_d = div_quo;
        end
`endif
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
          unique case (func_q)
            2'b00: begin
              out_d = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              ovf_d = sum[WIDTH];
            end
            2'b01: begin
              out_d = {{WIDTH{1'b0}}, diff};
              ovf_d = opa_q[WIDTH-1:0] < opb_q;
            end
            2'b10: begin
              out_d = mul_acc;
              ovf_d = 1'b0;
            end
            default: begin
`ifdef ALU_SEQ_DIV_EN
              if (div_zero) begin
                out_d = {{WIDTH{1'b1}}, opb_q};
                ovf_d = 1'b1;
              end else begin
                out_d = {div_quo, div_rem};
                ovf_d = 1'b0;
              end
`else
              out_d = '0;
              ovf_d = 1'b1;
`endif
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=6.
// Builds with or without ALU_SEQ_DIV_EN.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  func;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] out;
  logic        ovf;

  int n_checks;
  int n_fail;

  alu_seq #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .a(a), .b(b), .busy(busy), .done(done), .out(out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, scramble inputs after acceptance, wait for done.
  task automatic run_op(input logic [1:0] f, input logic [5:0] va,
                        input logic [5:0] vb, output int lat,
                        output int busy_bad, output logic busy_at_done);
    @(negedge clk);
    start = 1'b1; func = f; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; func = ~f; a = ~va; b = ~vb;
    lat = 0;
    busy_bad = 0;
    busy_at_done = 1'b1;
    if (!busy) busy_bad++;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        busy_at_done = busy;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if ({busy, done, out, ovf} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b out=%0d ovf=%b, want 0s",
               busy, done, out, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat, bb;
    logic bd;
    run_op(2'b00, 6'd40, 6'd30, lat, bb, bd);
    n_checks++;
    if (lat !== 1 || bd !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency: got %0d busy@done=%b, want 1 and 0", lat, bd);
    end
    n_checks++;
    if (out !== 12'd6 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL add_40_30: got out=%0d ovf=%b, want 6 1", out, ovf);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || out !== 12'd6 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL add_hold: got done=%b out=%0d ovf=%b, want 0 6 1",
               done, out, ovf);
    end
  endtask

  task automatic test_sub;
    int lat, bb;
    logic bd;
    run_op(2'b01, 6'd5, 6'd9, lat, bb, bd);
    n_checks++;
    if (lat !== 1 || out !== 12'd60 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_5_9: got lat=%0d out=%0d ovf=%b, want 1 60 1",
               lat, out, ovf);
    end
    run_op(2'b01, 6'd9, 6'd5, lat, bb, bd);
    n_checks++;
    if (lat !== 1 || out !== 12'd4 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_9_5: got lat=%0d out=%0d ovf=%b, want 1 4 0",
               lat, out, ovf);
    end
  endtask

  task automatic test_mul;
    int lat, bb;
    logic bd;
    run_op(2'b10, 6'd63, 6'd63, lat, bb, bd);
    n_checks++;
    if (lat !== 6 || bb !== 0 || bd !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_timing: got lat=%0d busy_gaps=%0d busy@done=%b, want 6 0 0",
               lat, bb, bd);
    end
    n_checks++;
    if (out !== 12'd3969 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_63_63: got out=%0d ovf=%b, want 3969 0", out, ovf);
    end
    run_op(2'b10, 6'd5, 6'd0, lat, bb, bd);
    n_checks++;
    if (lat !== 6 || out !== 12'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_5_0: got lat=%0d out=%0d ovf=%b, want 6 0 0",
               lat, out, ovf);
    end
  endtask

  task automatic test_div;
    int lat, bb;
    logic bd;
    run_op(2'b11, 6'd50, 6'd7, lat, bb, bd);
`ifdef ALU_SEQ_DIV_EN
    n_checks++;
    if (lat !== 6 || out !== 12'd449 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL div_50_7: got lat=%0d out=%0d ovf=%b, want 6 449 0",
               lat, out, ovf);
    end
`else
    n_checks++;
    if (lat !== 1 || out !== 12'd0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL div_off_50_7: got lat=%0d out=%0d ovf=%b, want 1 0 1",
               lat, out, ovf);
    end
`endif
    run_op(2'b11, 6'd13, 6'd0, lat, bb, bd);
`ifdef ALU_SEQ_DIV_EN
    n_checks++;
    if (lat !== 1 || out !== 12'd4045 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL div_13_0: got lat=%0d out=%0d ovf=%b, want 1 4045 1",
               lat, out, ovf);
    end
`else
    n_checks++;
    if (lat !== 1 || out !== 12'd0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL div_off_13_0: got lat=%0d out=%0d ovf=%b, want 1 0 1",
               lat, out, ovf);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int early;
    @(negedge clk);
    start = 1'b1; func = 2'b10; a = 6'd3; b = 6'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    early = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        start = 1'b1; func = 2'b00; a = 6'd1; b = 6'd1;
      end
      if (e == 3) start = 1'b0;
      if (e < 6 && done) early++;
    end
    n_checks++;
    if (early !== 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore_done: got early=%0d done=%b, want 0 1",
               early, done);
    end
    n_checks++;
    if (out !== 12'd12 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_out: got out=%0d ovf=%b, want 12 0", out, ovf);
    end
    start = 1'b1; func = 2'b00; a = 6'd1; b = 6'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || out !== 12'd12) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%b busy=%b out=%0d, want 0 1 12",
               done, busy, out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || out !== 12'd2 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_add: got done=%b out=%0d ovf=%b, want 1 2 0",
               done, out, ovf);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bb, seen;
    logic bd;
    @(negedge clk);
`ifdef ALU_SEQ_DIV_EN
    start = 1'b1; func = 2'b11; a = 6'd50; b = 6'd7;
`else
    start = 1'b1; func = 2'b10; a = 6'd50; b = 6'd7;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1; func = 2'b00; a = 6'd1; b = 6'd1;
    #1;
    n_checks++;
    if ({busy, done, out, ovf} !== 15'd0) begin
      n_fail++;
      $display("FAIL rst_abort: got busy=%b done=%b out=%0d ovf=%b, want 0s",
               busy, done, out, ovf);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d busy/done cycles, want 0", seen);
    end
    run_op(2'b00, 6'd2, 6'd3, lat, bb, bd);
    n_checks++;
    if (lat !== 1 || out !== 12'd5 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_then_add: got lat=%0d out=%0d ovf=%b, want 1 5 0",
               lat, out, ovf);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    func  = 2'b00;
    a     = '0;
    b     = '0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; accepted on a rising edge when busy=0.
REQ-005 SHALL have port func  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 SHALL have ports a, b  input  WIDTH each  unsigned operands.
REQ-007 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid out/ovf.
REQ-009 SHALL have port out  output  2*WIDTH  result register.
REQ-010 SHALL have port ovf  output  1  overflow/error flag register.

Function
REQ-011 SHALL implement states IDLE, RUN, FIN; IDLE->RUN on accepted start; RUN->FIN when iteration count expires; FIN->IDLE or FIN->RUN (new start) next edge.
REQ-012 SHALL latch a, b, func at the accepting edge k; later input changes do not affect the operation.
REQ-013 SHALL assert busy from edge k until the edge that asserts done; busy=0 in the done cycle.
REQ-014 add: out = {WIDTH zeros, (a+b) mod 2^WIDTH}, ovf = carry out; done at edge k+1.
REQ-015 sub: out = {WIDTH zeros, (a-b) mod 2^WIDTH}, ovf = 1 iff a<b; done at edge k+1.
REQ-016 mul: iterative shift-add, one bit per cycle; out = a*b (full 2*WIDTH bits), ovf=0; done at edge k+WIDTH.
REQ-017 div: iterative restoring division, one quotient bit per cycle; out[2W-1:W]=quotient, out[W-1:0]=remainder, ovf=0; done at edge k+WIDTH.
REQ-018 div with b=0: no iterations; out = {all ones, a}, ovf=1; done at edge k+1.
REQ-019 out and ovf SHALL change only on done edges and hold until the next done.
REQ-020 start while busy=1 SHALL be ignored (no queueing, no effect on current op).
REQ-021 start high in the done cycle SHALL be accepted (back-to-back ops, no idle gap).
REQ-022 done SHALL never be high for two consecutive cycles from one operation.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, busy=0, done=0, out=0, ovf=0, iteration counter=0.
REQ-024 rst asserted mid-operation SHALL abort it with no done pulse; start sampled while rst=1 is discarded.
REQ-025 after rst deasserts, first accepted start SHALL behave identically to a start after power-up.

Configuration
REQ-026 SHALL honour macro ALU_SEQ_DIV_EN: defined -> divider logic present, REQ-017/018 apply.
REQ-027 without ALU_SEQ_DIV_EN: no divider logic; func=11 completes at edge k+1 with out=0, ovf=1.

Verification (WIDTH=6)
REQ-028 add a=40 b=30 -> done 1 cycle after accept, out=6, ovf=1.
REQ-029 sub a=5 b=9 -> done after 1 cycle, out=60, ovf=1; sub a=9 b=5 -> out=4, ovf=0.
REQ-030 mul a=63 b=63 -> busy 6 cycles, done at edge k+6, out=3969, ovf=0.
REQ-031 div a=50 b=7 -> done at edge k+6, out=449 (q=7, r=1), ovf=0; div a=13 b=0 -> done at k+1, out=4045, ovf=1 (without ALU_SEQ_DIV_EN: out=0, ovf=1).
REQ-032 mul 3*4 started, start pulses with add 1+1 at cycles k+2 and k+3 -> ignored, single done with out=12; then add 1+1 issued in the done cycle -> done next edge, out=2.
REQ-033 div 50/7 started, rst pulsed at cycle k+3 -> busy/done/out/ovf all 0 immediately, no done pulse follows; subsequent add 2+3 -> out=5.
